// File: rtl/multiplier_pkg.sv
// multiplier_pkg: shared state type, step sizes and counter sizing for the multiplier control
package multiplier_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} seq_state_t;
  localparam int STEP_BITS_R2 = 1;
  localparam int STEP_BITS_R4 = 2;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/multiplier_step_counter.sv
// multiplier_step_counter: loadable down-counter of multiplier bits still to be retired
module multiplier_step_counter
  import multiplier_pkg::*;
#(
  parameter int C = 3
) (
  input  logic         clock,
  input  logic         n_reset,
  input  logic         i_load,
  input  logic [C-1:0] i_load_val,
  input  logic         i_dec,
  input  logic         i_dec2,
  input  logic         i_clr,
  output logic [C-1:0] o_count,
  output logic         o_is_zero,
  output logic         o_ge2
);
  logic [C-1:0] r_count;
  logic [C-1:0] w_dec_amt;
  // step size and status flags decoded from the held count
  always_comb begin
    w_dec_amt = i_dec2 ? C'(STEP_BITS_R4) : C'(STEP_BITS_R2);
    o_count = r_count;
    o_is_zero = r_count == '0;
    o_ge2 = r_count >= C'(STEP_BITS_R4);
  end
  // load wins over clear, clear over decrement; decrement saturates at zero
  always_ff @(posedge clock or negedge n_reset)
    if (!n_reset) r_count <= '0;
    else if (i_load) r_count <= i_load_val;
    else if (i_clr) r_count <= '0;
    else if (i_dec) r_count <= (r_count >= w_dec_amt) ? r_count - w_dec_amt : '0;
  // a decrement larger than the count means the sequencer chose a bad step size
  assert property (@(posedge clock) disable iff (!n_reset)
    (i_dec && !i_load && !i_clr) |-> (r_count >= w_dec_amt));
endmodule

// File: rtl/multiplier_sequencer.sv
// multiplier_sequencer: handshaked load/step/align controller for the shift-add multiplier
module multiplier_sequencer
  import multiplier_pkg::*;
#(
  parameter  int N = 4,
  localparam int C = cnt_width(N)
) (
  input  logic         clock,
  input  logic         n_reset,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [C-1:0] len,
  input  logic         radix4,
  input  logic         early_exit_en,
  input  logic         mult_zero,
  output logic         do_load,
  output logic         do_step,
  output logic         step2,
  output logic         do_align,
  output logic [C-1:0] align_bits,
  output logic         result_valid,
  input  logic         result_ready,
  output logic         busy,
  output logic [C-1:0] remaining
);
  seq_state_t   r_state;
  logic         r_radix4;
  logic         r_early;
  logic [C-1:0] w_count;
  logic [C-1:0] w_len_clamp;
  logic         w_accept;
  logic         w_exit;
  logic         w_last;
  logic         w_is_zero;
  logic         w_ge2;
  // outputs decode from held state and count; only the early-exit choice looks at mult_zero
  always_comb begin
    w_accept = r_state == IDLE && start_valid;
    w_len_clamp = (len > C'(N)) ? C'(N) : len;
    w_exit = r_state == RUN && r_early && mult_zero;
    do_step = r_state == RUN && !w_exit;
    step2 = do_step && r_radix4 && w_ge2;
    w_last = do_step && w_count == (step2 ? C'(STEP_BITS_R4) : C'(STEP_BITS_R2));
    do_align = w_exit;
    align_bits = w_exit ? w_count : '0;
    do_load = r_state == LOAD;
    start_ready = r_state == IDLE;
    result_valid = r_state == DONE;
    busy = r_state != IDLE;
    remaining = w_count;
  end
  // job control: capture modes on accept, leave RUN on last step or early exit
  always_ff @(posedge clock or negedge n_reset)
    if (!n_reset) begin
      r_state <= IDLE;
      r_radix4 <= 1'b0;
      r_early <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start_valid) begin
          r_state <= LOAD;
          r_radix4 <= radix4;
          r_early <= early_exit_en;
        end
        LOAD: r_state <= w_is_zero ? DONE : RUN;
        RUN: if (w_exit || w_last) r_state <= DONE;
        DONE: if (result_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  multiplier_step_counter #(.C(C)) u_counter (
    .clock      (clock),
    .n_reset    (n_reset),
    .i_load     (w_accept),
    .i_load_val (w_len_clamp),
    .i_dec      (do_step),
    .i_dec2     (step2),
    .i_clr      (w_exit),
    .o_count    (w_count),
    .o_is_zero  (w_is_zero),
    .o_ge2      (w_ge2)
  );
  // a step and an align in the same cycle would double-shift the datapath
  assert property (@(posedge clock) disable iff (!n_reset) !(do_step && do_align));
endmodule

// File: tb/tb_multiplier_sequencer.sv
// tb_multiplier_sequencer: directed and random jobs checked against a bit-retirement model
module tb_multiplier_sequencer;
  localparam int N = 8;
  localparam int C = $clog2(N + 1);
  logic clock = 1'b0;
  logic n_reset = 1'b0;
  logic start_valid = 1'b0;
  logic radix4 = 1'b0;
  logic early_exit_en = 1'b0;
  logic mult_zero = 1'b0;
  logic result_ready = 1'b0;
  logic [C-1:0] len = '0;
  logic start_ready, do_load, do_step, step2, do_align, result_valid, busy;
  logic [C-1:0] align_bits, remaining;
  int n_assert = 0;
  int n_fail = 0;
  multiplier_sequencer #(.N(N)) dut (
    .clock         (clock),
    .n_reset       (n_reset),
    .start_valid   (start_valid),
    .start_ready   (start_ready),
    .len           (len),
    .radix4        (radix4),
    .early_exit_en (early_exit_en),
    .mult_zero     (mult_zero),
    .do_load       (do_load),
    .do_step       (do_step),
    .step2         (step2),
    .do_align      (do_align),
    .align_bits    (align_bits),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .busy          (busy),
    .remaining     (remaining)
  );
  always #5 clock = ~clock;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic scramble();
    len = C'($urandom);
    radix4 = 1'($urandom);
    early_exit_en = 1'($urandom);
  endtask
  // model: the job retires min(len,N) bits, 2 at a time in radix-4 while at least 2 remain;
  // with early exit enabled the first cycle seeing mult_zero aligns away whatever remains
  task automatic job(input int l, input bit r4, input bit ee, input int zat, input int hold);
    int rem, take;
    bit mz;
    rem = (l > N) ? N : l;
    chk("idle_ready", 32'(start_ready), 1);
    start_valid = 1'b1;
    len = C'(l);
    radix4 = r4;
    early_exit_en = ee;
    @(posedge clock); #1;
    start_valid = 1'b0;
    scramble();
    mult_zero = 1'($urandom);
    #1;
    chk("load_strobe", 32'(do_load), 1);
    chk("load_ready", 32'(start_ready), 0);
    chk("load_busy", 32'(busy), 1);
    chk("load_step", 32'(do_step), 0);
    chk("load_align", 32'(do_align), 0);
    chk("load_remaining", 32'(remaining), 32'(rem));
    @(posedge clock); #1;
    for (int j = 0; rem > 0; j++) begin
      mz = zat >= 0 && j >= zat;
      mult_zero = mz;
      scramble();
      #1;
      chk("run_valid", 32'(result_valid), 0);
      chk("run_load", 32'(do_load), 0);
      chk("run_remaining", 32'(remaining), 32'(rem));
      if (ee && mz) begin
        chk("exit_align", 32'(do_align), 1);
        chk("exit_align_bits", 32'(align_bits), 32'(rem));
        chk("exit_step", 32'(do_step), 0);
        chk("exit_step2", 32'(step2), 0);
        rem = 0;
      end else begin
        take = (r4 && rem >= 2) ? 2 : 1;
        chk("run_step", 32'(do_step), 1);
        chk("run_step2", 32'(step2), 32'(take == 2));
        chk("run_align", 32'(do_align), 0);
        chk("run_align_bits", 32'(align_bits), 0);
        rem -= take;
      end
      @(posedge clock); #1;
    end
    start_valid = 1'b1;
    scramble();
    mult_zero = 1'($urandom);
    result_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      #1;
      chk("hold_valid", 32'(result_valid), 1);
      chk("hold_ready", 32'(start_ready), 0);
      chk("hold_strobes", 32'({do_load, do_step, do_align, step2}), 0);
      @(posedge clock); #1;
    end
    result_ready = 1'b1;
    #1;
    chk("done_valid", 32'(result_valid), 1);
    chk("done_remaining", 32'(remaining), 0);
    chk("done_strobes", 32'({do_load, do_step, do_align, step2}), 0);
    chk("done_align_bits", 32'(align_bits), 0);
    @(posedge clock); #1;
    result_ready = 1'b0;
    start_valid = 1'b0;
    mult_zero = 1'b0;
    #1;
    chk("after_ready", 32'(start_ready), 1);
    chk("after_valid", 32'(result_valid), 0);
    chk("after_busy", 32'(busy), 0);
  endtask
  initial begin
    #3;
    chk("rst_ready", 32'(start_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(result_valid), 0);
    chk("rst_remaining", 32'(remaining), 0);
    chk("rst_strobes", 32'({do_load, do_step, do_align, step2}), 0);
    @(negedge clock);
    n_reset = 1'b1;
    @(posedge clock); #1;
    job(4, 0, 0, -1, 3);
    job(7, 1, 0, -1, 0);
    job(8, 1, 1, 2, 1);
    job(0, 0, 0, -1, 1);
    job(15, 0, 0, -1, 0);
    job(3, 1, 0, -1, 0);
    job(5, 0, 1, -1, 0);
    job(6, 0, 1, 0, 0);
    start_valid = 1'b1;
    len = C'(6);
    radix4 = 1'b0;
    early_exit_en = 1'b0;
    @(posedge clock); #1;
    start_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("pre_reset_remaining", 32'(remaining), 3);
    chk("pre_reset_step", 32'(do_step), 1);
    #2;
    n_reset = 1'b0;
    #1;
    chk("mid_reset_ready", 32'(start_ready), 1);
    chk("mid_reset_busy", 32'(busy), 0);
    chk("mid_reset_remaining", 32'(remaining), 0);
    chk("mid_reset_outputs", 32'({do_load, do_step, do_align, step2, result_valid}), 0);
    @(negedge clock);
    n_reset = 1'b1;
    repeat (2) begin
      @(posedge clock); #1;
      chk("post_reset_valid", 32'(result_valid), 0);
      chk("post_reset_ready", 32'(start_ready), 1);
    end
    job(5, 1, 0, -1, 0);
    for (int i = 0; i < 30; i++)
      job($urandom_range(0, 15), 1'($urandom), 1'($urandom), int'($urandom_range(0, 6)) - 1,
          $urandom_range(0, 2));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
